// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the 16-state enum whose encoding doubles as the
// one-hot bit index of jtag_state, plus the fixed capture constants.
package jtag_tap_pkg;

  localparam int unsigned BIT_TLR  = 0;
  localparam int unsigned BIT_RTI  = 1;
  localparam int unsigned BIT_SDRS = 2;
  localparam int unsigned BIT_CDR  = 3;
  localparam int unsigned BIT_SDR  = 4;
  localparam int unsigned BIT_E1DR = 5;
  localparam int unsigned BIT_PDR  = 6;
  localparam int unsigned BIT_E2DR = 7;
  localparam int unsigned BIT_UDR  = 8;
  localparam int unsigned BIT_SIRS = 9;
  localparam int unsigned BIT_CIR  = 10;
  localparam int unsigned BIT_SIR  = 11;
  localparam int unsigned BIT_E1IR = 12;
  localparam int unsigned BIT_PIR  = 13;
  localparam int unsigned BIT_E2IR = 14;
  localparam int unsigned BIT_UIR  = 15;

  typedef enum logic [3:0] {
    ST_TLR  = 4'(BIT_TLR),
    ST_RTI  = 4'(BIT_RTI),
    ST_SDRS = 4'(BIT_SDRS),
    ST_CDR  = 4'(BIT_CDR),
    ST_SDR  = 4'(BIT_SDR),
    ST_E1DR = 4'(BIT_E1DR),
    ST_PDR  = 4'(BIT_PDR),
    ST_E2DR = 4'(BIT_E2DR),
    ST_UDR  = 4'(BIT_UDR),
    ST_SIRS = 4'(BIT_SIRS),
    ST_CIR  = 4'(BIT_CIR),
    ST_SIR  = 4'(BIT_SIR),
    ST_E1IR = 4'(BIT_E1IR),
    ST_PIR  = 4'(BIT_PIR),
    ST_E2IR = 4'(BIT_E2IR),
    ST_UIR  = 4'(BIT_UIR)
  } tap_state_e;

  localparam logic [1:0]  IR_CAPTURE_LSBS = 2'b01;
  localparam logic        BYPASS_CAPTURE  = 1'b0;
  localparam int unsigned IDCODE_WIDTH    = 32;

  function automatic logic [15:0] state_onehot(input tap_state_e s);
    logic [15:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register and tms-driven next-state logic.
// The next state is exported so the datapath can act on TLR entry.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state,
  output tap_state_e state_next
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:  state_d = tms ? ST_TLR  : ST_RTI;
      ST_RTI:  state_d = tms ? ST_SDRS : ST_RTI;
      ST_SDRS: state_d = tms ? ST_SIRS : ST_CDR;
      ST_CDR:  state_d = tms ? ST_E1DR : ST_SDR;
      ST_SDR:  state_d = tms ? ST_E1DR : ST_SDR;
      ST_E1DR: state_d = tms ? ST_UDR  : ST_PDR;
      ST_PDR:  state_d = tms ? ST_E2DR : ST_PDR;
      ST_E2DR: state_d = tms ? ST_UDR  : ST_SDR;
      ST_UDR:  state_d = tms ? ST_SDRS : ST_RTI;
      ST_SIRS: state_d = tms ? ST_TLR  : ST_CIR;
      ST_CIR:  state_d = tms ? ST_E1IR : ST_SIR;
      ST_SIR:  state_d = tms ? ST_E1IR : ST_SIR;
      ST_E1IR: state_d = tms ? ST_UIR  : ST_PIR;
      ST_PIR:  state_d = tms ? ST_E2IR : ST_PIR;
      ST_E2IR: state_d = tms ? ST_UIR  : ST_SIR;
      ST_UIR:  state_d = tms ? ST_SDRS : ST_RTI;
      default: state_d = ST_TLR;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_q <= ST_TLR;
    else         state_q <= state_d;
  end

  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/jtag_tap_multi_user.sv
// JTAG TAP with IR, bypass, optional IDCODE and NUM_USER decoded user DRs.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register and reset to IDCODE.
module jtag_tap_multi_user
  import jtag_tap_pkg::*;
#(
  parameter int unsigned                        IR_WIDTH      = 10,
  parameter int unsigned                        NUM_USER      = 2,
  parameter logic [NUM_USER*IR_WIDTH-1:0]       USER_OPCODES  = {10'h00E, 10'h00C},
  parameter logic [IR_WIDTH-1:0]                IDCODE_OPCODE = 10'h006,
  parameter logic [31:0]                        IDCODE_VALUE  = 32'h0000_0001
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic [NUM_USER-1:0] usr_tdo,
  output logic                tdo,
  output logic [15:0]         jtag_state,
  output logic [IR_WIDTH-1:0] ir_hold,
  output logic [NUM_USER-1:0] usr_sel,
  output logic                usr_shift
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OPCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = {IR_WIDTH{1'b1}};
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE_LSBS};

  tap_state_e state_q, state_d;

  logic                tdo_q, tdo_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_hold_q, ir_hold_d;
  logic                bypass_q, bypass_d;
  logic [NUM_USER-1:0] usr_sel_q, usr_sel_d;
  logic                usr_shift_q, usr_shift_d;
`ifdef JTAG_TAP_IDCODE_EN
  logic [IDCODE_WIDTH-1:0] idcode_q, idcode_d;
  logic                    idcode_sel_q, idcode_sel_d;
`endif

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .state      (state_q),
    .state_next (state_d)
  );

  // Duplicate opcodes resolve to the lowest channel; all-ones is always bypass.
  function automatic logic [NUM_USER-1:0] decode_user(input logic [IR_WIDTH-1:0] ir);
    logic [NUM_USER-1:0] sel;
    sel = '0;
    if (ir != {IR_WIDTH{1'b1}}) begin
      for (int k = NUM_USER - 1; k >= 0; k--) begin
        if (ir == USER_OPCODES[k*IR_WIDTH +: IR_WIDTH]) begin
          sel    = '0;
          sel[k] = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_hold_d  = ir_hold_q;
    bypass_d   = bypass_q;
    tdo_d      = tdo_q;
`ifdef JTAG_TAP_IDCODE_EN
    idcode_d   = idcode_q;
`endif
    case (state_q)
      ST_CIR: ir_shift_d = IR_CAPTURE;
      ST_SIR: begin
        ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        tdo_d      = ir_shift_q[0];
      end
      ST_UIR: ir_hold_d = ir_shift_q;
      ST_CDR: begin
        if (usr_sel_q == '0) begin
`ifdef JTAG_TAP_IDCODE_EN
          if (idcode_sel_q) idcode_d = IDCODE_VALUE;
          else              bypass_d = BYPASS_CAPTURE;
`else
          bypass_d = BYPASS_CAPTURE;
`endif
        end
      end
      ST_SDR: begin
        if (usr_sel_q != '0) begin
          tdo_d = |(usr_tdo & usr_sel_q);
        end else begin
`ifdef JTAG_TAP_IDCODE_EN
          if (idcode_sel_q) begin
            idcode_d = {tdi, idcode_q[IDCODE_WIDTH-1:1]};
            tdo_d    = idcode_q[0];
          end else begin
            bypass_d = tdi;
            tdo_d    = bypass_q;
          end
`else
          bypass_d = tdi;
          tdo_d    = bypass_q;
`endif
        end
      end
      default: ;
    endcase
    // Any transition into TLR restores the reset instruction on the same edge.
    if (state_d == ST_TLR) ir_hold_d = IR_RESET;

    usr_sel_d   = decode_user(ir_hold_d);
    usr_shift_d = (state_d == ST_SDR) && (usr_sel_d != '0);
`ifdef JTAG_TAP_IDCODE_EN
    idcode_sel_d = (ir_hold_d == IDCODE_OPCODE) && (ir_hold_d != {IR_WIDTH{1'b1}}) &&
                   (usr_sel_d == '0);
`endif
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q        <= 1'b0;
      ir_shift_q   <= '0;
      ir_hold_q    <= IR_RESET;
      bypass_q     <= 1'b0;
      usr_sel_q    <= '0;
      usr_shift_q  <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_q     <= '0;
      idcode_sel_q <= 1'b1;
`endif
    end else begin
      tdo_q        <= tdo_d;
      ir_shift_q   <= ir_shift_d;
      ir_hold_q    <= ir_hold_d;
      bypass_q     <= bypass_d;
      usr_sel_q    <= usr_sel_d;
      usr_shift_q  <= usr_shift_d;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_q     <= idcode_d;
      idcode_sel_q <= idcode_sel_d;
`endif
    end
  end

  assign tdo        = tdo_q;
  assign jtag_state = state_onehot(state_q);
  assign ir_hold    = ir_hold_q;
  assign usr_sel    = usr_sel_q;
  assign usr_shift  = usr_shift_q;

endmodule

// File: tb/tb_jtag_tap_multi_user.sv
// Directed bench for jtag_tap_multi_user; expectations follow JTAG_TAP_IDCODE_EN.
module tb_jtag_tap_multi_user;

  localparam int unsigned IR_W   = 10;
  localparam int unsigned NU     = 2;
  localparam logic [31:0] ID_VAL = 32'h1234_5679;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RST = 10'h006;
`else
  localparam logic [IR_W-1:0] IR_RST = 10'h3FF;
`endif

  logic            tck = 1'b0;
  logic            trst_n;
  logic            tms;
  logic            tdi;
  logic [NU-1:0]   usr_tdo;
  logic            tdo;
  logic [15:0]     jtag_state;
  logic [IR_W-1:0] ir_hold;
  logic [NU-1:0]   usr_sel;
  logic            usr_shift;

  int errors = 0;
  int checks = 0;

  jtag_tap_multi_user #(
    .IR_WIDTH      (IR_W),
    .NUM_USER      (NU),
    .USER_OPCODES  ({10'h00E, 10'h00C}),
    .IDCODE_OPCODE (10'h006),
    .IDCODE_VALUE  (ID_VAL)
  ) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .tdi        (tdi),
    .usr_tdo    (usr_tdo),
    .tdo        (tdo),
    .jtag_state (jtag_state),
    .ir_hold    (ir_hold),
    .usr_sel    (usr_sel),
    .usr_shift  (usr_shift)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: full IR scan of val, back in RTI; returns the tdo bits seen.
  task automatic shift_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] seen);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      tick(i == IR_W - 1, val[i]);
      seen[i] = tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    trst_n  = 1'b0;
    tms     = 1'b1;
    tdi     = 1'b0;
    usr_tdo = '0;
    repeat (2) @(posedge tck);
    #1;
    checks++; if (jtag_state !== 16'h0001) begin errors++; $display("FAIL reset_state: got %h expected %h", jtag_state, 16'h0001); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    checks++; if (ir_hold !== IR_RST) begin errors++; $display("FAIL reset_ir_hold: got %h expected %h", ir_hold, IR_RST); end
    checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL reset_usr_sel: got %b expected 00", usr_sel); end
    checks++; if (usr_shift !== 1'b0) begin errors++; $display("FAIL reset_usr_shift: got %b expected 0", usr_shift); end
    #2 trst_n = 1'b1;
    @(posedge tck);
    #1;
  endtask

  task automatic test_idcode;
    logic [31:0] pat;
    logic [31:0] seen;
    logic [31:0] exp;
    pat = 32'hA5C3_0F96;
`ifdef JTAG_TAP_IDCODE_EN
    exp = ID_VAL;
`else
    exp = {pat[30:0], 1'b0};
`endif
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, pat[i]);
      seen[i] = tdo;
    end
    checks++; if (seen !== exp) begin errors++; $display("FAIL idcode_stream: got %h expected %h", seen, exp); end
    tick(1'b1, 1'b1);
    checks++; if (tdo !== exp[31]) begin errors++; $display("FAIL tdo_hold_udr: got %b expected %b", tdo, exp[31]); end
    tick(1'b0, 1'b0);
    checks++; if (jtag_state !== 16'h0002) begin errors++; $display("FAIL state_rti: got %h expected 0002", jtag_state); end
  endtask

  task automatic test_ir_capture_bypass;
    logic [IR_W-1:0] seen;
    logic [7:0] pat;
    logic [7:0] got;
    logic [7:0] exp;
    shift_ir(10'h123, seen);
    checks++; if (seen !== 10'h001) begin errors++; $display("FAIL ir_capture: got %h expected 001", seen); end
    checks++; if (ir_hold !== 10'h123) begin errors++; $display("FAIL ir_hold_123: got %h expected 123", ir_hold); end
    checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL usr_sel_bypass: got %b expected 00", usr_sel); end
    pat = 8'b1011_0010;
    exp = {pat[6:0], 1'b0};
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (usr_shift !== 1'b0) begin errors++; $display("FAIL usr_shift_bypass: got %b expected 0", usr_shift); end
    for (int i = 0; i < 8; i++) begin
      tick(i == 7, pat[i]);
      got[i] = tdo;
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL bypass_stream: got %b expected %b", got, exp); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_user0;
    logic [IR_W-1:0] seen;
    shift_ir(10'h00C, seen);
    checks++; if (usr_sel !== 2'b01) begin errors++; $display("FAIL user0_sel: got %b expected 01", usr_sel); end
    checks++; if (ir_hold !== 10'h00C) begin errors++; $display("FAIL user0_ir_hold: got %h expected 00c", ir_hold); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (usr_shift !== 1'b1) begin errors++; $display("FAIL user0_shift: got %b expected 1", usr_shift); end
    usr_tdo = 2'b01;
    tick(1'b0, 1'b0);
    checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL user0_tdo_hi: got %b expected 1", tdo); end
    usr_tdo = 2'b10;
    tick(1'b1, 1'b1);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL user0_tdo_lo: got %b expected 0", tdo); end
    checks++; if (usr_shift !== 1'b0) begin errors++; $display("FAIL user0_shift_exit: got %b expected 0", usr_shift); end
    usr_tdo = 2'b00;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_user1_detour;
    logic [IR_W-1:0] val;
    val = 10'h00E;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(i == 4, val[i]);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (jtag_state !== 16'h2000) begin errors++; $display("FAIL detour_pir: got %h expected 2000", jtag_state); end
    checks++; if (usr_sel !== 2'b01) begin errors++; $display("FAIL detour_sel_pir: got %b expected 01", usr_sel); end
    tick(1'b1, 1'b0);
    checks++; if (ir_hold !== 10'h00C) begin errors++; $display("FAIL detour_hold_e2ir: got %h expected 00c", ir_hold); end
    tick(1'b0, 1'b0);
    for (int i = 5; i < 10; i++) tick(i == 9, val[i]);
    tick(1'b1, 1'b0);
    checks++; if (usr_sel !== 2'b01) begin errors++; $display("FAIL detour_sel_uir: got %b expected 01", usr_sel); end
    tick(1'b0, 1'b0);
    checks++; if (usr_sel !== 2'b10) begin errors++; $display("FAIL detour_sel_after: got %b expected 10", usr_sel); end
    checks++; if (ir_hold !== 10'h00E) begin errors++; $display("FAIL detour_ir_hold: got %h expected 00e", ir_hold); end
  endtask

  task automatic test_tlr_escape;
    logic [15:0] exp_st [5];
    exp_st[0] = 16'h0020;
    exp_st[1] = 16'h0100;
    exp_st[2] = 16'h0004;
    exp_st[3] = 16'h0200;
    exp_st[4] = 16'h0001;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (usr_shift !== 1'b1) begin errors++; $display("FAIL user1_shift: got %b expected 1", usr_shift); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      checks++; if (jtag_state !== exp_st[i]) begin errors++; $display("FAIL escape_state_%0d: got %h expected %h", i, jtag_state, exp_st[i]); end
    end
    checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL escape_usr_sel: got %b expected 00", usr_sel); end
    checks++; if (ir_hold !== IR_RST) begin errors++; $display("FAIL escape_ir_hold: got %h expected %h", ir_hold, IR_RST); end
    checks++; if (usr_shift !== 1'b0) begin errors++; $display("FAIL escape_usr_shift: got %b expected 0", usr_shift); end
  endtask

  task automatic test_reset_mid_sdr;
    logic [IR_W-1:0] seen;
    tick(1'b0, 1'b0);
    shift_ir(10'h00C, seen);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    usr_tdo = 2'b01;
    tick(1'b0, 1'b1);
    checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL mid_sdr_tdo_pre: got %b expected 1", tdo); end
    #3 trst_n = 1'b0;
    #1;
    checks++; if (jtag_state !== 16'h0001) begin errors++; $display("FAIL mid_sdr_state: got %h expected 0001", jtag_state); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL mid_sdr_tdo: got %b expected 0", tdo); end
    checks++; if (ir_hold !== IR_RST) begin errors++; $display("FAIL mid_sdr_ir_hold: got %h expected %h", ir_hold, IR_RST); end
    checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL mid_sdr_usr_sel: got %b expected 00", usr_sel); end
    #2 trst_n = 1'b1;
    usr_tdo = 2'b00;
    @(posedge tck);
    #1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (jtag_state !== 16'h0002) begin errors++; $display("FAIL post_reset_state: got %h expected 0002", jtag_state); end
    checks++; if (ir_hold !== IR_RST) begin errors++; $display("FAIL post_reset_ir_hold: got %h expected %h", ir_hold, IR_RST); end
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_ir_capture_bypass;
    test_user0;
    test_user1_detour;
    test_tlr_escape;
    test_reset_mid_sdr;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_multi_user.md
JTAG_TAP_MULTI_USER -- requirements
Module: jtag_tap_multi_user

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 10, instruction register width (range 4..32).
REQ-002 SHALL have parameter NUM_USER, default 2, number of decoded user instructions (range 1..8).
REQ-003 SHALL have parameter USER_OPCODES, default {10'h00E,10'h00C}, flat NUM_USER*IR_WIDTH vector; slice k is the opcode of user channel k.
REQ-004 SHALL have parameter IDCODE_OPCODE, default 10'h006, IDCODE instruction.
REQ-005 SHALL have parameter IDCODE_VALUE, default 32'h0000_0001, value shifted out for IDCODE; bit 0 SHALL be 1.
REQ-006 SHALL have port tck  input  1  the only clock; all flops on posedge.
REQ-007 SHALL have port trst_n  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port tms  input  1  mode select, sampled on posedge tck.
REQ-009 SHALL have port tdi  input  1  serial data in.
REQ-010 SHALL have port usr_tdo  input  NUM_USER  serial return from user data register k.
REQ-011 SHALL have port tdo  output  1  registered serial data out.
REQ-012 SHALL have port jtag_state  output  16  one-hot current TAP state, bit order per package.
REQ-013 SHALL have port ir_hold  output  IR_WIDTH  active instruction.
REQ-014 SHALL have port usr_sel  output  NUM_USER  one-hot; bit k high while ir_hold equals opcode k.
REQ-015 SHALL have port usr_shift  output  1  high in SDR while any usr_sel bit is high.

Function
REQ-016 FSM SHALL implement the 16 IEEE 1149.1 states and tms transitions; 5 consecutive tms=1 cycles from any state reach TLR.
REQ-017 jtag_state SHALL be exactly one-hot every cycle after reset.
REQ-018 In CIR the IR shift register SHALL load {IR_WIDTH-2 zeros, 2'b01}.
REQ-019 In SIR the IR shift register SHALL shift right with tdi entering the MSB; tdo SHALL present the LSB one cycle later.
REQ-020 ir_hold SHALL update from the IR shift register only on the cycle in UIR; PIR/E2IR SHALL not disturb ir_hold.
REQ-021 Unknown opcodes and all-ones SHALL select the 1-bit bypass register (captures 0 in CDR, shifts tdi in SDR).
REQ-022 With IDCODE selected, CDR SHALL load IDCODE_VALUE into a 32-bit register shifted LSB-first in SDR.
REQ-023 With user k selected, tdo SHALL follow usr_tdo[k] registered one cycle; bypass/IDCODE flops SHALL hold.
REQ-024 Outside SIR/SDR, tdo SHALL hold its last value.
REQ-025 If two USER_OPCODES slices are equal, the lowest k SHALL win; usr_sel stays one-hot.
REQ-026 Entry to TLR via tms SHALL synchronously reload ir_hold to its reset value on the same edge.

Reset
REQ-027 trst_n low SHALL asynchronously force: state TLR, jtag_state bit TLR=1, tdo=0, IR shift=0, bypass=0, usr_sel=0, usr_shift=0.
REQ-028 ir_hold reset value SHALL be IDCODE_OPCODE when IDCODE is compiled in, else all-ones (BYPASS).
REQ-029 Reset asserted mid-shift SHALL discard the partial IR/DR contents; no ir_hold update occurs.

Configuration
REQ-030 Macro JTAG_TAP_IDCODE_EN defined: IDCODE opcode, 32-bit IDCODE register and reset-to-IDCODE are built.
REQ-031 Macro undefined: no IDCODE register; IDCODE_OPCODE decodes as bypass; ir_hold resets to all-ones.

Structure
REQ-032 Package jtag_tap_pkg SHALL hold the 16-state enum, one-hot bit indices, BYPASS/CIR capture constants.
REQ-033 Sub-module jtag_tap_fsm SHALL hold state register and next-state logic only; datapath stays in the top.

Verification
REQ-034 trst_n low mid-SDR -> jtag_state=16'h0001 (TLR), tdo=0, ir_hold=10'h006 (IDCODE_EN) or 10'h3FF.
REQ-035 Shift IR 10'h00C, UIR -> usr_sel=2'b01; SDR with usr_tdo[0]=1 -> tdo=1 one cycle later, usr_shift=1.
REQ-036 Shift IR 10'h00E via PIR/E2IR detour -> usr_sel=2'b10 only after UIR.
REQ-037 Reset then CDR, 32 SDR cycles -> tdo sequence equals IDCODE_VALUE LSB-first; undefined macro -> single 0 then tdi delayed.
REQ-038 IR scan -> first 2 tdo bits 1,0 (captured 01); shift opcode 10'h123 -> bypass, tdo=tdi delayed 1 after leading 0.
REQ-039 tms=1 for 5 cycles from SDR with user selected -> TLR, usr_sel=0, ir_hold reset value.
